// File: rtl/d_reg_multimode_pkg.sv
// Shared definitions for the multimode CPU register: operation encodings on the Mode port.
package d_reg_multimode_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_INC  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

endpackage

// File: rtl/d_reg_slice.sv
// One bit of the multimode register: 4:1 next-value mux feeding a flop with sync clear.
module d_reg_slice
  import d_reg_multimode_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  clr,
  input  mode_e sel,
  input  logic  load_bit,
  input  logic  sum_bit,
  input  logic  shift_bit,
  output logic  q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RESET_BIT;
    end else begin
      unique case (sel)
        MODE_HOLD: q <= q;
        MODE_LOAD: q <= load_bit;
        MODE_INC:  q <= sum_bit;
        MODE_SHL:  q <= shift_bit;
      endcase
    end
  end

endmodule

// File: rtl/d_reg_multimode.sv
// General-purpose CPU register with per-cycle hold/load/increment/shift-left, sync clear,
// serial I/O, registered carry-out pulse and zero flag.
module d_reg_multimode
  import d_reg_multimode_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             Si,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             So,
  output logic             Co,
  output logic             Zero
);

  mode_e            sel;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] shift_val;

  // En=0 collapses every mode to hold; Clr is applied inside each slice and the Co flop.
  assign sel     = En ? mode_e'(Mode) : MODE_HOLD;
  assign inc_sum = {1'b0, Q} + (WIDTH+1)'(1);

  generate
    if (WIDTH == 1) begin : g_shift_narrow
      assign shift_val = Si;
    end else begin : g_shift_wide
      assign shift_val = {Q[WIDTH-2:0], Si};
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      d_reg_slice #(
        .RESET_BIT (RESET_VAL[i])
      ) u_slice (
        .clk       (Clk),
        .clr       (Clr),
        .sel       (sel),
        .load_bit  (D[i]),
        .sum_bit   (inc_sum[i]),
        .shift_bit (shift_val[i]),
        .q         (Q[i])
      );
    end
  endgenerate

  // Carry pulse: set only by a wrapping INC, cleared by every other edge.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      Co <= 1'b0;
    end else begin
      Co <= (sel == MODE_INC) && inc_sum[WIDTH];
    end
  end

  assign Qn   = ~Q;
  assign So   = Q[WIDTH-1];
  assign Zero = (Q == '0);

endmodule

// File: tb/tb_d_reg_multimode.sv
// Bench for d_reg_multimode: three widths (6, 1, 16) driven in lockstep, directed cases
// followed by random traffic against an arithmetic reference model.
module tb_d_reg_multimode;
  import d_reg_multimode_pkg::*;

  logic        clk = 1'b0;
  logic        clr, en, si;
  logic [1:0]  mode;
  logic [15:0] d;

  logic [5:0]  q6, qn6;
  logic        so6, co6, z6;
  logic [0:0]  q1, qn1;
  logic        so1, co1, z1;
  logic [15:0] q16, qn16;
  logic        so16, co16, z16;

  longint m6, m1, m16;
  bit     mc6, mc1, mc16;
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  d_reg_multimode #(.WIDTH(6), .RESET_VAL(6'h2A)) u_w6 (
    .Clk(clk), .Clr(clr), .En(en), .Mode(mode), .D(d[5:0]), .Si(si),
    .Q(q6), .Qn(qn6), .So(so6), .Co(co6), .Zero(z6));

  d_reg_multimode #(.WIDTH(1), .RESET_VAL(1'b1)) u_w1 (
    .Clk(clk), .Clr(clr), .En(en), .Mode(mode), .D(d[0:0]), .Si(si),
    .Q(q1), .Qn(qn1), .So(so1), .Co(co1), .Zero(z1));

  d_reg_multimode #(.WIDTH(16), .RESET_VAL(16'h8001)) u_w16 (
    .Clk(clk), .Clr(clr), .En(en), .Mode(mode), .D(d), .Si(si),
    .Q(q16), .Qn(qn16), .So(so16), .Co(co16), .Zero(z16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint ref_q(input int w, input longint q, input bit e,
                                   input logic [1:0] md, input longint dv, input bit s);
    longint m = longint'(1) << w;
    if (!e) return q;
    case (md)
      2'b01:   return dv % m;
      2'b10:   return (q + 1) % m;
      2'b11:   return (q * 2 + longint'(s)) % m;
      default: return q;
    endcase
  endfunction

  function automatic bit ref_co(input int w, input longint q, input bit e, input logic [1:0] md);
    longint m = longint'(1) << w;
    return e && (md == 2'b10) && (q == m - 1);
  endfunction

  task automatic check_model();
    chk("q6",    32'(q6),   32'(m6));
    chk("qn6",   32'(qn6),  32'((~m6) & 63));
    chk("so6",   32'(so6),  32'((m6 >> 5) & 1));
    chk("co6",   32'(co6),  32'(mc6));
    chk("zero6", 32'(z6),   32'(m6 == 0));
    chk("q1",    32'(q1),   32'(m1));
    chk("qn1",   32'(qn1),  32'((~m1) & 1));
    chk("so1",   32'(so1),  32'(m1));
    chk("co1",   32'(co1),  32'(mc1));
    chk("zero1", 32'(z1),   32'(m1 == 0));
    chk("q16",   32'(q16),  32'(m16));
    chk("qn16",  32'(qn16), 32'((~m16) & 16'hFFFF));
    chk("so16",  32'(so16), 32'((m16 >> 15) & 1));
    chk("co16",  32'(co16), 32'(mc16));
    chk("zero16",32'(z16),  32'(m16 == 0));
  endtask

  task automatic apply(input bit c, input bit e, input logic [1:0] md,
                       input logic [15:0] dv, input bit s);
    clr = c; en = e; mode = md; d = dv; si = s;
    @(posedge clk);
    if (c) begin
      m6 = 'h2A; m1 = 1; m16 = 'h8001;
      mc6 = 0; mc1 = 0; mc16 = 0;
    end else begin
      mc6  = ref_co(6,  m6,  e, md);
      mc1  = ref_co(1,  m1,  e, md);
      mc16 = ref_co(16, m16, e, md);
      m6   = ref_q(6,  m6,  e, md, longint'(dv), s);
      m1   = ref_q(1,  m1,  e, md, longint'(dv), s);
      m16  = ref_q(16, m16, e, md, longint'(dv), s);
    end
    #1;
    check_model();
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; si = 1'b0;
    m6 = 0; m1 = 0; m16 = 0;
    @(negedge clk);

    // Reset wins over an enabled LOAD on the same edge.
    apply(1, 1, MODE_LOAD, 16'h0015, 0);
    chk("rst_q",    32'(q6),  32'h2A);
    chk("rst_qn",   32'(qn6), 32'h15);
    chk("rst_co",   32'(co6), 32'h0);
    chk("rst_zero", 32'(z6),  32'h0);
    chk("rst_q16",  32'(q16), 32'h8001);

    apply(0, 1, MODE_LOAD, 16'h003C, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, MODE_LOAD, 16'h0001, 0);
    chk("hold_q",  32'(q6),  32'h3C);
    chk("hold_so", 32'(so6), 32'h1);

    apply(0, 1, MODE_LOAD, 16'h003E, 0);
    apply(0, 1, MODE_INC, 16'h0000, 0);
    chk("inc1_q", 32'(q6), 32'h3F); chk("inc1_co", 32'(co6), 0); chk("inc1_z", 32'(z6), 0);
    apply(0, 1, MODE_INC, 16'h0000, 0);
    chk("inc2_q", 32'(q6), 32'h00); chk("inc2_co", 32'(co6), 1); chk("inc2_z", 32'(z6), 1);
    apply(0, 1, MODE_INC, 16'h0000, 0);
    chk("inc3_q", 32'(q6), 32'h01); chk("inc3_co", 32'(co6), 0); chk("inc3_z", 32'(z6), 0);

    apply(0, 1, MODE_LOAD, 16'h0025, 0);
    chk("shl0_so", 32'(so6), 1);
    apply(0, 1, MODE_SHL, 16'h0000, 1);
    chk("shl1_q", 32'(q6), 32'h0B); chk("shl1_so", 32'(so6), 0);
    apply(0, 1, MODE_SHL, 16'h0000, 0);
    chk("shl2_q", 32'(q6), 32'h16); chk("shl2_so", 32'(so6), 0);

    apply(0, 1, MODE_LOAD, 16'h003F, 0);
    apply(1, 1, MODE_INC, 16'h0000, 0);
    chk("clrmid_q", 32'(q6), 32'h2A); chk("clrmid_co", 32'(co6), 0);

    // Wide and single-bit wrap: all three registers hold all-ones before the INC.
    apply(0, 1, MODE_LOAD, 16'hFFFF, 0);
    apply(0, 1, MODE_INC, 16'h0000, 0);
    chk("w16_q", 32'(q16), 32'h0000); chk("w16_co", 32'(co16), 1);
    chk("w1_q",  32'(q1),  0);        chk("w1_co",  32'(co1),  1);
    apply(0, 1, MODE_INC, 16'h0000, 0);
    chk("w16_co_drop", 32'(co16), 0);
    chk("w1_toggle",   32'(q1),   1);
    apply(0, 1, MODE_SHL, 16'h0000, 0);
    chk("w1_shl0", 32'(q1), 0);
    apply(0, 1, MODE_SHL, 16'h0000, 1);
    chk("w1_shl1", 32'(q1), 1);

    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 16) == 0, ($urandom % 4) != 0, 2'($urandom),
            16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
